// File: rtl/lcd_line_writer.sv
// lcd_line_writer
//   Drives an HD44780-style character LCD over an 8-bit bus. After reset (or on
//   INIT_REQ) it sends the function-set / display-on / entry-mode / clear init
//   sequence. On START it copies a NUM_LINES x CHARS character buffer to the
//   display. Each line is a DDRAM address command followed by CHARS data writes.
//
//   Optional feature: define LCD_AUTO_REFRESH_EN to add parameter
//   REFRESH_PERIOD. The block then starts a screen write by itself when it has
//   been idle for that long.
//
// Ports
//   CLK        clock; all logic runs on the rising edge
//   RESET      asynchronous, active-high reset
//   START      request one full-screen write (taken only in IDLE)
//   INIT_REQ   request a re-run of the init sequence (latched at any time)
//   BUSY       high whenever the FSM is not in IDLE
//   DONE       one-cycle pulse at the end of a screen write
//   CHAR_ADDR  buffer index = line*CHARS + column, held for the whole FETCH
//   CHAR_DATA  buffer byte, valid one cycle after CHAR_ADDR
//   LCD_RS/LCD_RW/LCD_E/LCD_DATA  HD44780 bus (RW is tied low)
//   STATE_DBG  current FSM state, for debug and checker binding
//
// Request semantics: START and INIT_REQ are level requests with no ready
// return. START is sampled only in IDLE; if it arrives while BUSY it is
// dropped, not queued. INIT_REQ is latched in any state. The latch is acted
// on when no bus transaction is in flight.
//
// Each bus transaction has three phases:
//   - 1 setup cycle with E low;
//   - CMD_HOLD cycles with E high;
//   - a wait with E low (CLR_WAIT after the clear command, CMD_WAIT otherwise).
// RS and DATA stay stable for the whole transaction. CMD_WAIT and CLR_WAIT
// must be at least 1.
module lcd_line_writer #(
    parameter int NUM_LINES = 2,
    parameter int CHARS     = 16,
    parameter int CMD_HOLD  = 12,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 80000
`ifdef LCD_AUTO_REFRESH_EN
    ,
    parameter int REFRESH_PERIOD = 5000000
`endif
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       INIT_REQ,
    output logic       BUSY,
    output logic       DONE,
    output logic [((NUM_LINES*CHARS > 1) ? $clog2(NUM_LINES*CHARS) : 1)-1:0] CHAR_ADDR,
    input  logic [7:0] CHAR_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DATA,
    output logic [3:0] STATE_DBG
);

    localparam int AW   = (NUM_LINES*CHARS > 1) ? $clog2(NUM_LINES*CHARS) : 1;
    localparam int LW   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int COLW = (CHARS > 1) ? $clog2(CHARS) : 1;
    localparam int MAXW = (CMD_HOLD > CMD_WAIT) ?
                          ((CMD_HOLD > CLR_WAIT) ? CMD_HOLD : CLR_WAIT) :
                          ((CMD_WAIT > CLR_WAIT) ? CMD_WAIT : CLR_WAIT);
    // Sized for the largest wait, so the counter never wraps.
    localparam int CW   = $clog2(MAXW + 1);

    localparam logic [CW-1:0]   HOLD_LAST = CW'(CMD_HOLD - 1);
    localparam logic [CW-1:0]   CMD_LAST  = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0]   CLR_LAST  = CW'(CLR_WAIT - 1);
    localparam logic [LW-1:0]   LINE_LAST = LW'(NUM_LINES - 1);
    localparam logic [COLW-1:0] COL_LAST  = COLW'(CHARS - 1);
    // Function set: 8-bit bus, 2-line mode unless only one line is used.
    localparam logic [7:0]      FS_CMD    = (NUM_LINES == 1) ? 8'h30 : 8'h38;

    typedef enum logic [3:0] {
        INIT_FS, INIT_ON, INIT_ENT, INIT_CLR, IDLE,
        SET_ADDR, FETCH, WRITE_CHAR, FINISH
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_HOLD, PH_WAIT} phase_t;

    state_t          state_q, state_n;
    phase_t          phase_q, phase_n;
    logic [CW-1:0]   cnt_q, cnt_n, wait_last;
    logic [7:0]      data_q, data_n;
    logic            rs_q, rs_n;
    logic [LW-1:0]   line_q, line_n;
    logic [COLW-1:0] col_q, col_n;
    logic            init_done_q, init_done_n;
    logic            start_pend_q, start_pend_n;
    logic            init_pend_q;
    logic            is_tx, tx_end, go_init, go_screen, init_wanted;
    logic            refresh_fire;

    // DDRAM set-address command for the start of each display line.
    function automatic logic [7:0] line_cmd(input int l);
        case (l)
            1:       line_cmd = 8'hC0;
            2:       line_cmd = 8'h94;
            3:       line_cmd = 8'hD4;
            default: line_cmd = 8'h80;
        endcase
    endfunction

`ifdef LCD_AUTO_REFRESH_EN
    localparam int RFW = $clog2(REFRESH_PERIOD + 1);
    localparam logic [RFW-1:0] RF_LAST = RFW'(REFRESH_PERIOD - 1);
    logic [RFW-1:0] refresh_cnt_q;

    // The count starts in the FINISH cycle, so an automatic write begins
    // REFRESH_PERIOD cycles after DONE. START restarts the count. The counter
    // saturates instead of wrapping.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            refresh_cnt_q <= '0;
        end else if (START || !(state_q == IDLE || state_q == FINISH)) begin
            refresh_cnt_q <= '0;
        end else if (refresh_cnt_q != RF_LAST) begin
            refresh_cnt_q <= refresh_cnt_q + RFW'(1);
        end
    end

    assign refresh_fire = (state_q == IDLE) && (refresh_cnt_q == RF_LAST);
`else
    assign refresh_fire = 1'b0;
`endif

    assign is_tx       = (state_q != IDLE) && (state_q != FETCH) && (state_q != FINISH);
    assign wait_last   = (state_q == INIT_CLR) ? CLR_LAST : CMD_LAST;
    assign init_wanted = init_pend_q | INIT_REQ;

    always_comb begin
        state_n      = state_q;
        phase_n      = phase_q;
        cnt_n        = cnt_q;
        data_n       = data_q;
        rs_n         = rs_q;
        line_n       = line_q;
        col_n        = col_q;
        init_done_n  = init_done_q;
        start_pend_n = start_pend_q;
        tx_end       = 1'b0;
        go_init      = 1'b0;
        go_screen    = 1'b0;

        if (is_tx) begin
            case (phase_q)
                PH_SETUP: begin
                    phase_n = PH_HOLD;
                    cnt_n   = '0;
                end
                PH_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        phase_n = PH_WAIT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (cnt_q == wait_last) tx_end = 1'b1;
                    else                    cnt_n  = cnt_q + CW'(1);
                end
            endcase
        end

        case (state_q)
            IDLE: begin
                // A START that arrives together with an init request waits
                // for the init sequence and then runs.
                if (!init_done_q || init_wanted) begin
                    go_init      = 1'b1;
                    start_pend_n = START;
                end else if (START || refresh_fire) begin
                    go_screen = 1'b1;
                end
            end
            FETCH: begin
                // Two cycles: address out, then capture the byte on the
                // edge that opens the WRITE_CHAR setup cycle.
                if (init_wanted) begin
                    go_init = 1'b1;
                end else if (cnt_q == '0) begin
                    cnt_n = CW'(1);
                end else begin
                    state_n = WRITE_CHAR;
                    phase_n = PH_SETUP;
                    cnt_n   = '0;
                    data_n  = CHAR_DATA;
                    rs_n    = 1'b1;
                end
            end
            FINISH: state_n = IDLE;
            default: begin
                if (tx_end) begin
                    phase_n = PH_SETUP;
                    cnt_n   = '0;
                    if (init_wanted) begin
                        go_init = 1'b1;
                    end else begin
                        case (state_q)
                            INIT_FS:  begin state_n = INIT_ON;  data_n = 8'h0C; end
                            INIT_ON:  begin state_n = INIT_ENT; data_n = 8'h06; end
                            INIT_ENT: begin state_n = INIT_CLR; data_n = 8'h01; end
                            INIT_CLR: begin
                                init_done_n = 1'b1;
                                if (start_pend_q) go_screen = 1'b1;
                                else              state_n   = IDLE;
                            end
                            SET_ADDR: state_n = FETCH;
                            WRITE_CHAR: begin
                                if (col_q != COL_LAST) begin
                                    col_n   = col_q + COLW'(1);
                                    state_n = FETCH;
                                end else if (line_q == LINE_LAST) begin
                                    state_n = FINISH;
                                end else begin
                                    line_n  = line_q + LW'(1);
                                    col_n   = '0;
                                    state_n = SET_ADDR;
                                    data_n  = line_cmd(int'(line_q) + 1);
                                    rs_n    = 1'b0;
                                end
                            end
                            default: state_n = IDLE;
                        endcase
                    end
                end
            end
        endcase

        if (go_screen) begin
            state_n      = SET_ADDR;
            phase_n      = PH_SETUP;
            cnt_n        = '0;
            line_n       = '0;
            col_n        = '0;
            data_n       = 8'h80;
            rs_n         = 1'b0;
            start_pend_n = 1'b0;
        end
        if (go_init) begin
            state_n = INIT_FS;
            phase_n = PH_SETUP;
            cnt_n   = '0;
            data_n  = FS_CMD;
            rs_n    = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            phase_q      <= PH_SETUP;
            cnt_q        <= '0;
            data_q       <= 8'h00;
            rs_q         <= 1'b0;
            line_q       <= '0;
            col_q        <= '0;
            init_done_q  <= 1'b0;
            start_pend_q <= 1'b0;
            init_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_n;
            phase_q      <= phase_n;
            cnt_q        <= cnt_n;
            data_q       <= data_n;
            rs_q         <= rs_n;
            line_q       <= line_n;
            col_q        <= col_n;
            init_done_q  <= init_done_n;
            start_pend_q <= start_pend_n;
            if (go_init)       init_pend_q <= 1'b0;
            else if (INIT_REQ) init_pend_q <= 1'b1;
        end
    end

    assign LCD_E     = (phase_q == PH_HOLD);
    assign LCD_RS    = rs_q;
    assign LCD_RW    = 1'b0;
    assign LCD_DATA  = data_q;
    assign BUSY      = (state_q != IDLE);
    assign DONE      = (state_q == FINISH);
    assign CHAR_ADDR = AW'(int'(line_q) * CHARS + int'(col_q));
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_lcd_line_writer.sv
// Testbench for lcd_line_writer (NUM_LINES=2, CHARS=4, CMD_HOLD=2,
// CMD_WAIT=4, CLR_WAIT=10). A negedge monitor records every rising edge of
// LCD_E as {RS, DATA, cycle}. The recorded bus traffic is compared with an
// expected queue built from the HD44780 command list and the buffer contents.
module tb_lcd_line_writer;
    localparam int NL = 2;
    localparam int NC = 4;

    // clock / reset
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RESET, START, INIT_REQ;
    logic       BUSY, DONE, LCD_RS, LCD_RW, LCD_E;
    logic [2:0] CHAR_ADDR;
    logic [7:0] CHAR_DATA, LCD_DATA;
    logic [3:0] STATE_DBG;

    lcd_line_writer #(
        .NUM_LINES(NL), .CHARS(NC), .CMD_HOLD(2), .CMD_WAIT(4), .CLR_WAIT(10)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .INIT_REQ(INIT_REQ),
        .BUSY(BUSY), .DONE(DONE), .CHAR_ADDR(CHAR_ADDR), .CHAR_DATA(CHAR_DATA),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E), .LCD_DATA(LCD_DATA),
        .STATE_DBG(STATE_DBG)
    );

    // Character buffer: synchronous-read memory.
    logic [7:0] mem [NL*NC];
    always @(posedge CLK) CHAR_DATA <= mem[CHAR_ADDR];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // bus monitor
    logic [7:0] ev_data[$];
    logic       ev_rs[$];
    int         ev_cyc[$];
    int   done_cnt = 0, busy_rise_cnt = 0, busy_rise_cyc = 0, busy_fall_cyc = 0, rw_bad = 0;
    logic e_prev = 1'b0, b_prev = 1'b0;

    always @(negedge CLK) begin
        if (LCD_E && !e_prev) begin
            ev_data.push_back(LCD_DATA);
            ev_rs.push_back(LCD_RS);
            ev_cyc.push_back(cyc);
        end
        if (DONE) done_cnt++;
        if (BUSY && !b_prev) begin busy_rise_cnt++; busy_rise_cyc = cyc; end
        if (!BUSY && b_prev) busy_fall_cyc = cyc;
        if (LCD_RW !== 1'b0) rw_bad++;
        e_prev = LCD_E;
        b_prev = BUSY;
    end

    // scoreboard
    logic [8:0] exp_q[$];
    logic [7:0] line_base [4] = '{8'h00, 8'h40, 8'h14, 8'h54};
    int n_checks = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    task automatic expect_screen(input int n_items);
        int k = 0;
        for (int l = 0; l < NL; l++) begin
            if (k < n_items) exp_q.push_back({1'b0, 8'h80 | line_base[l]});
            k++;
            for (int c = 0; c < NC; c++) begin
                if (k < n_items) exp_q.push_back({1'b1, mem[l*NC + c]});
                k++;
            end
        end
    endtask

    task automatic compare_events(input string tag, input int base);
        chk({tag, "_count"}, ev_data.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < ev_data.size())
                chk($sformatf("%s[%0d]", tag, i), {23'd0, ev_rs[base+i], ev_data[base+i]}, {23'd0, exp_q[i]});
        end
        exp_q.delete();
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin @(negedge CLK); #1; end
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        tick(2);
        while (BUSY && n < max_cyc) begin tick(1); n++; end
        chk("idle_timeout", {31'd0, BUSY}, 32'd0);
    endtask

    task automatic pulse_start();
        START = 1'b1; tick(1); START = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NL*NC; i++) mem[i] = 8'($urandom_range(8'h20, 8'h7E));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d0, r0, n;
        string s;
        RESET = 1'b1; START = 1'b0; INIT_REQ = 1'b0;
        for (int i = 0; i < NL*NC; i++) mem[i] = 8'h00;
        tick(3);

        // reset values
        chk("rst_e",    {31'd0, LCD_E},  0);
        chk("rst_rs",   {31'd0, LCD_RS}, 0);
        chk("rst_rw",   {31'd0, LCD_RW}, 0);
        chk("rst_data", {24'd0, LCD_DATA}, 0);
        chk("rst_busy", {31'd0, BUSY}, 0);
        chk("rst_done", {31'd0, DONE}, 0);
        chk("rst_addr", {29'd0, CHAR_ADDR}, 0);

        // init sequence after release
        base = ev_data.size();
        RESET = 1'b0;
        wait_idle(200);
        chk("init_busy_cycles", busy_fall_cyc - busy_rise_cyc, 34);
        expect_init();
        compare_events("init", base);
        if (ev_cyc.size() >= base + 4) begin
            chk("init_first_e", ev_cyc[base] - busy_rise_cyc, 1);
            for (int k = 1; k < 4; k++)
                chk($sformatf("init_gap%0d", k), ev_cyc[base+k] - ev_cyc[base+k-1], 7);
        end

        // directed screen write
        s = "ABCDWXYZ";
        for (int i = 0; i < NL*NC; i++) mem[i] = s[i];
        base = ev_data.size(); d0 = done_cnt;
        pulse_start();
        wait_idle(400);
        expect_screen(NL*(NC+1));
        compare_events("abcd", base);
        chk("abcd_done", done_cnt - d0, 1);

        // random buffers
        for (int r = 0; r < 3; r++) begin
            fill_random();
            base = ev_data.size(); d0 = done_cnt;
            pulse_start();
            wait_idle(400);
            expect_screen(NL*(NC+1));
            compare_events($sformatf("rand%0d", r), base);
            chk($sformatf("rand%0d_done", r), done_cnt - d0, 1);
        end

        // START held high for the whole write
        fill_random();
        base = ev_data.size(); d0 = done_cnt; r0 = busy_rise_cnt;
        START = 1'b1;
        n = 0;
        while (!DONE && n < 400) begin tick(1); n++; end
        chk("held_done_seen", {31'd0, DONE}, 1);
        START = 1'b0;
        tick(30);
        expect_screen(NL*(NC+1));
        compare_events("held", base);
        chk("held_done", done_cnt - d0, 1);
        chk("held_busy_rises", busy_rise_cnt - r0, 1);

        // INIT_REQ during the 3rd character
        fill_random();
        base = ev_data.size(); d0 = done_cnt;
        pulse_start();
        n = 0;
        while (ev_data.size() < base + 4 && n < 400) begin tick(1); n++; end
        INIT_REQ = 1'b1; tick(1); INIT_REQ = 1'b0;
        wait_idle(400);
        expect_screen(4);
        expect_init();
        compare_events("initreq", base);
        chk("initreq_no_done", done_cnt - d0, 0);

        // reset in the middle of an E pulse
        fill_random();
        pulse_start();
        n = 0;
        while (!LCD_E && n < 100) begin tick(1); n++; end
        RESET = 1'b1;
        #1;
        chk("midrst_e",    {31'd0, LCD_E}, 0);
        chk("midrst_data", {24'd0, LCD_DATA}, 0);
        chk("midrst_busy", {31'd0, BUSY}, 0);
        tick(2);
        base = ev_data.size();
        RESET = 1'b0;
        wait_idle(200);
        chk("midrst_busy_cycles", busy_fall_cyc - busy_rise_cyc, 34);
        expect_init();
        compare_events("midrst_init", base);

        // START and INIT_REQ together in IDLE: init first, then the write
        fill_random();
        base = ev_data.size(); d0 = done_cnt;
        START = 1'b1; INIT_REQ = 1'b1;
        tick(1);
        START = 1'b0; INIT_REQ = 1'b0;
        wait_idle(600);
        expect_init();
        expect_screen(NL*(NC+1));
        compare_events("both", base);
        chk("both_done", done_cnt - d0, 1);

        chk("rw_low", rw_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
